// File: rtl/mem_requester_pkg.sv
// Shared definitions for the memory requester, the memory model and the CU:
// opcodes, completion status codes, FSM encodings and small decode helpers.
package mem_requester_pkg;

  typedef logic [5:0] opcode_t;

  // Memory opcodes
  localparam opcode_t OP_LD   = 6'b000000;
  localparam opcode_t OP_LDUB = 6'b000001;
  localparam opcode_t OP_LDUH = 6'b000010;
  localparam opcode_t OP_LDD  = 6'b000011;
  localparam opcode_t OP_ST   = 6'b000100;
  localparam opcode_t OP_STB  = 6'b000101;
  localparam opcode_t OP_STH  = 6'b000110;
  localparam opcode_t OP_STD  = 6'b000111;
  localparam opcode_t OP_LDSB = 6'b001001;
  localparam opcode_t OP_LDSH = 6'b001010;

  // Completion status, valid while Done is high
  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_MSET  = 2'b10;
  localparam logic [1:0] ERR_TMO   = 2'b11;

  // Requester FSM encodings
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_NEXT   = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  // Request as latched from the CU
  typedef struct packed {
    opcode_t     op;
    logic [31:0] addr;
    logic [63:0] data;
  } req_t;

  // Doubleword ops are split into two word accesses
  function automatic logic is_dw(input opcode_t op);
    return (op == OP_LDD) || (op == OP_STD);
  endfunction

  // Ops that return data on MFC
  function automatic logic is_load(input opcode_t op);
    return op inside {OP_LD, OP_LDUB, OP_LDUH, OP_LDD, OP_LDSB, OP_LDSH};
  endfunction

  // Natural alignment: DW on 8, word on 4, half on 2, bytes anywhere
  function automatic logic align_ok(input opcode_t op, input logic [31:0] addr);
    logic ok;
    case (op)
      OP_LDD, OP_STD:          ok = (addr[2:0] == 3'b000);
      OP_LD, OP_ST:            ok = (addr[1:0] == 2'b00);
      OP_LDUH, OP_LDSH, OP_STH: ok = (addr[0] == 1'b0);
      default:                 ok = 1'b1;
    endcase
    return ok;
  endfunction

  // Opcode placed on the bus: DW halves go out as plain word accesses
  function automatic opcode_t bus_op(input opcode_t op);
    opcode_t o;
    case (op)
      OP_LDD:  o = OP_LD;
      OP_STD:  o = OP_ST;
      default: o = op;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mem_requester_if.sv
// Word-wide memory bus between the requester (master) and memory (slave).
// Each Enable transition starts exactly one access; MFC/MSET report its end.
interface mem_requester_if;
  import mem_requester_pkg::*;

  logic        Enable;
  opcode_t     OpCode;
  logic [31:0] MAR_Address;
  logic [31:0] MDR_DataIn;
  logic [31:0] MDR_DataOut;
  logic        MFC;
  logic        MSET;

  modport master (
    output Enable, OpCode, MAR_Address, MDR_DataIn,
    input  MDR_DataOut, MFC, MSET
  );

  modport slave (
    input  Enable, OpCode, MAR_Address, MDR_DataIn,
    output MDR_DataOut, MFC, MSET
  );

endinterface

// File: rtl/mem_requester.sv
// Memory requester: takes one CU request, checks alignment, runs one or two
// word accesses on the toggle-triggered memory bus, and reports completion
// with a one-cycle Done pulse plus status.
module mem_requester
  import mem_requester_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  opcode_t      i_req_op,
  input  logic [31:0]  i_req_addr,
  input  logic [63:0]  i_req_data,
  output logic         o_busy,
  output logic         o_done,
  output logic [1:0]   o_err,
  output logic [63:0]  o_rd_data,
  mem_requester_if.master mem
);

  // Counter only needs to reach TIMEOUT_CYC-1 (the last WAIT cycle)
  localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  logic [2:0]    r_state, w_state_nxt;
  logic [1:0]    w_fin_err;
  req_t          r_req;
  logic [31:0]   r_addr;
  logic          r_second;
  logic [CW-1:0] r_cnt;
  logic          r_enable;
  opcode_t       r_opcode;
  logic [31:0]   r_mar;
  logic [31:0]   r_mdr_in;
  logic [1:0]    r_err;
  logic [63:0]   r_rd_data;
  logic [31:0]   r_rd_hi;

  logic w_dw, w_dw_first, w_load, w_first, w_mset, w_mfc, w_tmo;

  assign w_dw       = is_dw(r_req.op);
  assign w_dw_first = w_dw && !r_second;
  assign w_load     = is_load(r_req.op);
  // First WAIT cycle: memory is still clearing MFC/MSET from the last access
  assign w_first    = (r_cnt == '0);
  assign w_mset     = !w_first && mem.MSET;
  // MSET wins over a simultaneous MFC
  assign w_mfc      = !w_first && mem.MFC && !mem.MSET;
  assign w_tmo      = (r_cnt == CNT_LAST);

  // Next-state and final status selection
  always_comb begin
    w_state_nxt = r_state;
    w_fin_err   = ERR_OK;
    case (r_state)
      S_IDLE:   if (i_start) w_state_nxt = S_CHECK;
      S_CHECK: begin
        if (align_ok(r_req.op, r_req.addr)) begin
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_FINISH;
          w_fin_err   = ERR_ALIGN;
        end
      end
      S_ISSUE:  w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_mset) begin
          w_state_nxt = S_FINISH;
          w_fin_err   = ERR_MSET;
        end else if (w_mfc) begin
          w_state_nxt = w_dw_first ? S_NEXT : S_FINISH;
        end else if (w_tmo) begin
          w_state_nxt = S_FINISH;
          w_fin_err   = ERR_TMO;
        end
      end
      S_NEXT:   w_state_nxt = S_ISSUE;
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Latch the request only when idle; Start while busy is dropped
  always_ff @(posedge i_clk) begin
    if (i_rst)                             r_req <= '0;
    else if (r_state == S_IDLE && i_start) r_req <= {i_req_op, i_req_addr, i_req_data};
  end

  // Access address and half tracking for doubleword requests
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr   <= '0;
      r_second <= 1'b0;
    end else if (r_state == S_CHECK) begin
      r_addr   <= r_req.addr;
      r_second <= 1'b0;
    end else if (r_state == S_NEXT) begin
      r_addr   <= r_addr + 32'd4;
      r_second <= 1'b1;
    end
  end

  // Bus drive: held from ISSUE through WAIT, Enable toggles once per access
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_enable <= 1'b0;
      r_opcode <= '0;
      r_mar    <= '0;
      r_mdr_in <= '0;
    end else if (r_state == S_ISSUE) begin
      r_enable <= ~r_enable;
      r_opcode <= bus_op(r_req.op);
      r_mar    <= r_addr;
      r_mdr_in <= w_dw_first ? r_req.data[63:32] : r_req.data[31:0];
    end
  end

  // Per-access wait counter, restarted on each issue
  always_ff @(posedge i_clk) begin
    if (i_rst)                                             r_cnt <= '0;
    else if (r_state == S_ISSUE)                           r_cnt <= '0;
    else if (r_state == S_WAIT && w_state_nxt == S_WAIT)   r_cnt <= r_cnt + 1'b1;
  end

  // Completion status, captured on entry to FINISH and held after
  always_ff @(posedge i_clk) begin
    if (i_rst)                                               r_err <= ERR_OK;
    else if (w_state_nxt == S_FINISH && r_state != S_FINISH) r_err <= w_fin_err;
  end

  // Load data: DW first word is staged so RdData only changes on completion
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_data <= '0;
      r_rd_hi   <= '0;
    end else if (r_state == S_WAIT && w_mfc && w_load) begin
      if (w_dw_first)  r_rd_hi   <= mem.MDR_DataOut;
      else if (w_dw)   r_rd_data <= {r_rd_hi, mem.MDR_DataOut};
      else             r_rd_data <= {32'h0, mem.MDR_DataOut};
    end
  end

  assign o_busy          = (r_state != S_IDLE);
  assign o_done          = (r_state == S_FINISH);
  assign o_err           = r_err;
  assign o_rd_data       = r_rd_data;
  assign mem.Enable      = r_enable;
  assign mem.OpCode      = r_opcode;
  assign mem.MAR_Address = r_mar;
  assign mem.MDR_DataIn  = r_mdr_in;

endmodule
